piso_serializer: RTL and testbench

Parallel-in/serial-out stage that sits directly downstream of the 8-bit D-register bank. It accepts one latched parallel word per LOAD/READY handshake and shifts it out on a single serial line at a programmable bit rate. It frames each word with a one-cycle DONE pulse and then returns to idle. It is the first serial stage feeding the board's single-wire output path, such as an LED driver or a bit-banged link.

---
 rtl/piso_serializer_pkg.sv | 13 +
 rtl/piso_serializer_if.sv | 26 ++
 rtl/piso_serializer_div.sv | 31 +++
 rtl/piso_serializer.sv | 115 +++++++++++
 tb/tb_piso_serializer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial output path: FSM state encoding and idle line level.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Level the serial line rests at whenever no word is being shifted.
  localparam logic SO_IDLE = 1'b1;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-load / serial-out handshake bundle between the D-register bank and the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             so;
  logic             bit_stb;
  logic             busy;
  logic             done;

  // Upstream side: offers a word and watches the serial outputs.
  modport master (
    output din, load,
    input  ready, so, bit_stb, busy, done
  );

  // Serializer side.
  modport slave (
    input  din, load,
    output ready, so, bit_stb, busy, done
  );

endinterface

// File: rtl/piso_serializer_div.sv
// Modulo-DIV bit-rate counter: marks the first and last clock of every serial bit.
module bit_rate_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic strobe
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] count;

  assign tick   = (count == DIV_W'(DIV - 1));
  assign strobe = (count == '0);

  // Count 0..DIV-1 while enabled; clear restarts the first bit of a new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes one word per LOAD/READY handshake and shifts it
// out on SO at DIV clocks per bit, then frames it with a one-cycle DONE pulse.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 0
) (
  input logic              clk,
  input logic              rst,
  piso_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             shifting;
  logic             last_bit;
  logic             tick;
  logic             bit_start;

  // Move the next bit to transmit into the head position.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) begin
      return {w[WIDTH-2:0], 1'b0};
    end
    return {1'b0, w[WIDTH-1:1]};
  endfunction

  // Bit currently at the head of the word, i.e. the one driven on SO.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  assign accept     = (state == IDLE) && bus.load;
  assign shifting   = (state == SHIFT);
  assign last_bit   = (bit_cnt == CNT_W'(WIDTH - 1));
  assign shreg_next = shift_word(shreg);

  bit_rate_div #(
    .DIV (DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (shifting),
    .tick   (tick),
    .strobe (bit_start)
  );

  // Control FSM with shift register, bit counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      bus.so      <= SO_IDLE;
      bus.ready   <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bit_stb <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.bit_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            state       <= SHIFT;
            shreg       <= bus.din;
            bit_cnt     <= '0;
            bus.so      <= head_bit(bus.din);
            bus.bit_stb <= 1'b1;
            bus.ready   <= 1'b0;
            bus.busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (last_bit) begin
              // Last bit has been held its full period; counters stay put until the next load.
              state    <= DONE;
              bus.so   <= SO_IDLE;
              bus.done <= 1'b1;
            end else begin
              shreg       <= shreg_next;
              bit_cnt     <= bit_cnt + CNT_W'(1);
              bus.so      <= head_bit(shreg_next);
              bus.bit_stb <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
          bus.busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bus.so    <= SO_IDLE;
          bus.ready <= 1'b1;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

  // The registered bit strobe must coincide with the divider's bit-start count while shifting.
  assert property (@(posedge clk) disable iff (rst) shifting |-> (bus.bit_stb == bit_start));

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized scoreboard bench for piso_serializer: two instances (DIV=4 LSB-first and
// DIV=1 MSB-first) checked cycle by cycle against a timeline model of the output.
module tb_piso_serializer;

  localparam int W     = 8;
  localparam int DIV_A = 4;
  localparam int DIV_B = 1;

  typedef struct {
    int   at;
    logic so;
    logic stb;
    logic done;
    logic busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   edge_no = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   free_a  = 0;
  int   free_b  = 0;
  exp_t qa[$];
  exp_t qb[$];

  piso_serializer_if #(.WIDTH(W)) ifa ();
  piso_serializer_if #(.WIDTH(W)) ifb ();

  piso_serializer #(.WIDTH(W), .DIV(DIV_A), .MSB_FIRST(0)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa.slave)
  );

  piso_serializer #(.WIDTH(W), .DIV(DIV_B), .MSB_FIRST(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // Bit number k of the transmitted sequence for a word.
  function automatic logic word_bit(input logic [W-1:0] w, input int k, input bit msb);
    logic [W-1:0] t;
    t = w;
    return msb ? t[W-1-k] : t[k];
  endfunction

  // Word accepted at edge e: every output cycle until the DONE pulse is predicted.
  task automatic push_word(input int id, input int e, input logic [W-1:0] w);
    int   div;
    bit   msb;
    exp_t x;
    div = (id == 0) ? DIV_A : DIV_B;
    msb = (id != 0);
    for (int k = 0; k < W; k++) begin
      for (int j = 0; j < div; j++) begin
        x.at   = e + k * div + j;
        x.so   = word_bit(w, k, msb);
        x.stb  = (j == 0);
        x.done = 1'b0;
        x.busy = 1'b1;
        if (id == 0) qa.push_back(x); else qb.push_back(x);
      end
    end
    x.at   = e + W * div;
    x.so   = 1'b1;
    x.stb  = 1'b0;
    x.done = 1'b1;
    x.busy = 1'b1;
    if (id == 0) qa.push_back(x); else qb.push_back(x);
  endtask

  // Apply inputs for the upcoming edge and decide acceptance from the word-period rule.
  task automatic drive(input int id, input logic ld, input logic [W-1:0] d);
    if (id == 0) begin
      ifa.load = ld;
      ifa.din  = d;
      if (ld && !rst_a && edge_no >= free_a) begin
        push_word(0, edge_no, d);
        free_a = edge_no + W * DIV_A + 2;
      end
    end else begin
      ifb.load = ld;
      ifb.din  = d;
      if (ld && !rst_b && edge_no >= free_b) begin
        push_word(1, edge_no, d);
        free_b = edge_no + W * DIV_B + 2;
      end
    end
  endtask

  task automatic cyc(input logic la, input logic [W-1:0] da, input logic lb, input logic [W-1:0] db);
    @(negedge clk);
    drive(0, la, da);
    drive(1, lb, db);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0);
  endtask

  // Compare one cycle of outputs with the predicted timeline entry (or the idle line).
  task automatic mon(input int id, input int e, input logic [4:0] act);
    exp_t       x;
    logic [4:0] exp_v;
    x.at   = e;
    x.so   = 1'b1;
    x.stb  = 1'b0;
    x.done = 1'b0;
    x.busy = 1'b0;
    if (id == 0) begin
      if (qa.size() > 0 && qa[0].at == e) x = qa.pop_front();
    end else begin
      if (qb.size() > 0 && qb[0].at == e) x = qb.pop_front();
    end
    exp_v = {x.so, x.stb, x.busy, ~x.busy, x.done};
    check((id == 0) ? "cycle_a{so,stb,busy,ready,done}" : "cycle_b{so,stb,busy,ready,done}",
          int'(act), int'(exp_v));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon(0, edge_no - 1, {ifa.so, ifa.bit_stb, ifa.busy, ifa.ready, ifa.done});
      mon(1, edge_no - 1, {ifb.so, ifb.bit_stb, ifb.busy, ifb.ready, ifb.done});
    end
  end

  // Mid-shift abort on instance A after nbit full bits of word d.
  task automatic abort_a(input logic [W-1:0] d, input int nbit);
    cyc(1'b1, d, 1'b0, '0);
    idle(nbit * DIV_A + 1);
    rst_a = 1'b1;
    qa.delete();
    free_a = 0;
    #1;
    check("abort_async{so,busy,ready,done,stb}",
          int'({ifa.so, ifa.busy, ifa.ready, ifa.done, ifa.bit_stb}), int'(5'b10100));
    idle(2);
    rst_a = 1'b0;
    idle(40);
  endtask

  initial begin
    ifa.load = 1'b0;
    ifa.din  = '0;
    ifb.load = 1'b0;
    ifb.din  = '0;
    rst_a    = 1'b1;
    rst_b    = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle(6);

    // LSB-first word with a LOAD attempt ten edges into the shift.
    cyc(1'b1, 8'hA5, 1'b0, '0);
    idle(9);
    cyc(1'b1, 8'hFF, 1'b0, '0);
    idle(30);

    // Asynchronous aborts: bit 3 of 8'h3C, and a word whose line is low at the abort.
    abort_a(8'h3C, 3);
    abort_a(8'h00, 5);

    // MSB-first, one clock per bit.
    cyc(1'b0, '0, 1'b1, 8'h81);
    idle(12);

    // LOAD held high: back-to-back words with the DONE/IDLE gap in between.
    cyc(1'b1, 8'h01, 1'b0, '0);
    for (int i = 0; i < 69; i++) cyc(1'b1, 8'h80, 1'b0, '0);
    idle(40);

    // Random traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) == 0, W'($urandom), $urandom_range(0, 2) == 0, W'($urandom));
    end
    idle(50);

    check("queue_drain", qa.size() + qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
